// File: rtl/d5m_pkg.sv
// Shared types and constants for the D5M sensor emulator: FSM states, test patterns
// and the pixel/coordinate widths used between the top and the pattern generator.
package d5m_pkg;

    localparam int D5M_DW = 12;
    localparam int D5M_CW = 12;

    typedef enum logic [2:0] {
        IDLE,
        FRONT,
        LINE,
        HBLANK,
        BACK,
        VBLANK
    } d5m_state_t;

    typedef enum logic [1:0] {
        RAMP,
        CHECKER,
        BAYER,
        CONST
    } d5m_mode_t;

    function automatic int d5m_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/d5m_pattern_pix.sv
// Combinational test-pattern pixel generator: one 12-bit pixel value from the
// latched pattern mode, the pixel coordinates, the frame number and the constant value.
module d5m_pattern_pix
    import d5m_pkg::*;
(
    input  logic [1:0]        mode_i,
    input  logic [D5M_CW-1:0] x_i,
    input  logic [D5M_CW-1:0] y_i,
    input  logic [D5M_DW-1:0] frame_i,
    input  logic [D5M_DW-1:0] const_val_i,
    output logic [D5M_DW-1:0] pix_o
);

    logic [D5M_DW-1:0] bar;

    // Colour bars step every 8 pixels, 16 codes per step.
    assign bar = {x_i[10:3], 4'h0};

    always_comb begin
        pix_o = '0;
        case (d5m_mode_t'(mode_i))
            RAMP:    pix_o = x_i + y_i + frame_i;
            CHECKER: pix_o = (x_i[3] ^ y_i[3]) ? 12'hFFF : 12'h000;
            BAYER: begin
                if (!y_i[0]) pix_o = x_i[0] ? bar : 12'h800;
                else         pix_o = x_i[0] ? 12'h800 : (12'hFFF - bar);
            end
            CONST:   pix_o = const_val_i;
            default: pix_o = '0;
        endcase
    end

endmodule

// File: rtl/d5m_sensor_emu.sv
// MT9P001-style D5M parallel bus transmitter: frame/line timing FSM, counters and
// registered D5M_D/FVAL/LVAL outputs, with a selectable test pattern.
module d5m_sensor_emu
    import d5m_pkg::*;
#(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 960,
    parameter int H_BLANK  = 160,
    parameter int FRONT    = 20,
    parameter int BACK     = 20,
    parameter int V_BLANK  = 2000
) (
    input  logic                D5M_PIXCLK,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                trigger,
    input  logic [1:0]          mode,
    input  logic [D5M_DW-1:0]   const_val,
    output logic [D5M_DW-1:0]   D5M_D,
    output logic                D5M_FVAL,
    output logic                D5M_LVAL,
    output logic [15:0]         frame_cnt,
    output logic                busy
);

    localparam int MAXP = d5m_max(d5m_max(d5m_max(H_ACTIVE, V_ACTIVE), d5m_max(H_BLANK, FRONT)),
                                  d5m_max(BACK, V_BLANK));
    localparam int CW = $clog2(MAXP + 1);

    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [CW-1:0] H_LAST  = CW'(H_ACTIVE - 1);
    localparam logic [CW-1:0] V_LAST  = CW'(V_ACTIVE - 1);
    localparam logic [CW-1:0] HB_LAST = CW'(H_BLANK - 1);
    localparam logic [CW-1:0] FR_LAST = CW'(FRONT - 1);
    localparam logic [CW-1:0] BK_LAST = CW'(BACK - 1);
    localparam logic [CW-1:0] VB_LAST = CW'(V_BLANK - 1);

    d5m_state_t        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [CW-1:0]     x_q, x_d;
    logic [CW-1:0]     y_q, y_d;
    logic [1:0]        mode_q, mode_d;
    logic [D5M_DW-1:0] cval_q, cval_d;
    logic [15:0]       fcnt_q, fcnt_d;
    logic              fval_q, lval_q, busy_q;
    logic [D5M_DW-1:0] data_q;
    logic [D5M_DW-1:0] pix;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        mode_d  = mode_q;
        cval_d  = cval_q;
        fcnt_d  = fcnt_q;
        case (state_q)
            d5m_pkg::IDLE: begin
                if (enable || trigger) begin
                    state_d = d5m_pkg::FRONT;
                    cnt_d   = '0;
                    x_d     = '0;
                    y_d     = '0;
                    mode_d  = mode;
                    cval_d  = const_val;
                end
            end
            d5m_pkg::FRONT: begin
                if (cnt_q == FR_LAST) begin
                    state_d = d5m_pkg::LINE;
                    x_d     = '0;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            d5m_pkg::LINE: begin
                if (x_q == H_LAST) begin
                    cnt_d   = '0;
                    state_d = (y_q == V_LAST) ? d5m_pkg::BACK : d5m_pkg::HBLANK;
                end else begin
                    x_d = x_q + ONE;
                end
            end
            d5m_pkg::HBLANK: begin
                if (cnt_q == HB_LAST) begin
                    state_d = d5m_pkg::LINE;
                    x_d     = '0;
                    y_d     = y_q + ONE;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            d5m_pkg::BACK: begin
                if (cnt_q == BK_LAST) begin
                    state_d = d5m_pkg::VBLANK;
                    cnt_d   = '0;
                    fcnt_d  = fcnt_q + 16'd1;
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            d5m_pkg::VBLANK: begin
                if (cnt_q == VB_LAST) begin
                    cnt_d = '0;
                    // Only continuous mode chains frames; a late trigger is not queued.
                    if (enable) begin
                        state_d = d5m_pkg::FRONT;
                        x_d     = '0;
                        y_d     = '0;
                        mode_d  = mode;
                        cval_d  = const_val;
                    end else begin
                        state_d = d5m_pkg::IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            default: state_d = d5m_pkg::IDLE;
        endcase
    end

    // Pixel is computed from next-cycle coordinates so D5M_D lines up with LVAL.
    d5m_pattern_pix u_pix (
        .mode_i      (mode_d),
        .x_i         (D5M_CW'(x_d)),
        .y_i         (D5M_CW'(y_d)),
        .frame_i     (fcnt_q[D5M_DW-1:0]),
        .const_val_i (cval_d),
        .pix_o       (pix)
    );

    always_ff @(posedge D5M_PIXCLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= d5m_pkg::IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            mode_q  <= '0;
            cval_q  <= '0;
            fcnt_q  <= '0;
            fval_q  <= 1'b0;
            lval_q  <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            mode_q  <= mode_d;
            cval_q  <= cval_d;
            fcnt_q  <= fcnt_d;
            fval_q  <= (state_d != d5m_pkg::IDLE) && (state_d != d5m_pkg::VBLANK);
            lval_q  <= (state_d == d5m_pkg::LINE);
            busy_q  <= (state_d != d5m_pkg::IDLE);
            data_q  <= (state_d == d5m_pkg::LINE) ? pix : '0;
        end
    end

    assign D5M_D     = data_q;
    assign D5M_FVAL  = fval_q;
    assign D5M_LVAL  = lval_q;
    assign frame_cnt = fcnt_q;
    assign busy      = busy_q;

endmodule
